instr_fetcher: RTL and testbench

Per-core instruction fetch unit. It consumes the thread PC value and the core_state sequencing that the PC unit uses. It reads one 16-bit instruction word from program memory over a valid/ready read channel and presents it to the decoder. It sits between the core scheduler/PC path and the program-memory controller channel assigned to the core.

---
 rtl/instr_fetcher_pkg.sv | 24 ++
 rtl/instr_fetch_cache.sv | 62 ++++++
 rtl/instr_fetcher.sv | 149 ++++++++++++++
 tb/tb_instr_fetcher.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetcher_pkg.sv
// Shared encodings and widths for the instruction fetch unit and its optional cache.
package instr_fetcher_pkg;

    localparam int PC_BITS    = 8;
    localparam int INSTR_BITS = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE = 3'b000,
        FETCHING     = 3'b001,
        FETCHED      = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/instr_fetch_cache.sv
// Direct-mapped instruction cache: combinational lookup, fill on a completed memory read,
// flush of all valid bits. Flush takes priority over a coincident fill.
module instr_fetch_cache
    import instr_fetcher_pkg::*;
#(
    parameter int ADDR_BITS = PC_BITS,
    parameter int DATA_BITS = INSTR_BITS,
    parameter int ENTRIES   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    output logic                 hit,
    output logic [DATA_BITS-1:0] hit_data,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_pc,
    input  logic [DATA_BITS-1:0] fill_data,
    input  logic                 flush
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [TAG_BITS-1:0]  tag_r  [ENTRIES];
    logic [DATA_BITS-1:0] data_r [ENTRIES];
    logic [ENTRIES-1:0]   valid_r;

    logic [IDX_BITS-1:0] lookup_idx_s;
    logic [TAG_BITS-1:0] lookup_tag_s;
    logic [IDX_BITS-1:0] fill_idx_s;
    logic [TAG_BITS-1:0] fill_tag_s;

    assign lookup_idx_s = lookup_pc[IDX_BITS-1:0];
    assign lookup_tag_s = lookup_pc[ADDR_BITS-1:IDX_BITS];
    assign fill_idx_s   = fill_pc[IDX_BITS-1:0];
    assign fill_tag_s   = fill_pc[ADDR_BITS-1:IDX_BITS];

    assign hit      = valid_r[lookup_idx_s] && (tag_r[lookup_idx_s] == lookup_tag_s);
    assign hit_data = data_r[lookup_idx_s];

    // Valid bits: cleared by reset or flush, set by a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[fill_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage; contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[fill_idx_s]  <= fill_tag_s;
            data_r[fill_idx_s] <= fill_data;
        end
    end

endmodule

// File: rtl/instr_fetcher.sv
// Per-core instruction fetch unit: one valid/ready program-memory read per FETCH, sticky timeout.
// Optional direct-mapped cache enabled with the FETCH_CACHE_EN macro.
module instr_fetcher
    import instr_fetcher_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = PC_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = INSTR_BITS,
    parameter int TIMEOUT_CYCLES        = 255,
    parameter int CACHE_ENTRIES         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             cache_flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_timeout
);

    localparam int                CNT_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT_CYCLES);

    fetcher_state_t                   state_r, state_next;
    logic                             valid_r, valid_next;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_r, addr_next;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_r, instr_next;
    logic [CNT_BITS-1:0]              cnt_r, cnt_next;
    logic                             timeout_r, timeout_next;

    logic                             hit_s;
    logic [PROGRAM_MEM_DATA_BITS-1:0] hit_data_s;

`ifdef FETCH_CACHE_EN
    logic fill_en_s;

    assign fill_en_s = (state_r == FETCHING) && mem_read_ready;

    instr_fetch_cache #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .ENTRIES   (CACHE_ENTRIES)
    ) u_cache (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (current_pc),
        .hit       (hit_s),
        .hit_data  (hit_data_s),
        .fill_en   (fill_en_s),
        .fill_pc   (addr_r),
        .fill_data (mem_read_data),
        .flush     (cache_flush)
    );
`else
    localparam bit CACHE_POW2 = ((CACHE_ENTRIES & (CACHE_ENTRIES - 1)) == 0);
    logic unused_cfg_s;

    assign hit_s        = 1'b0;
    assign hit_data_s   = '0;
    assign unused_cfg_s = cache_flush ^ CACHE_POW2;
`endif

    // Next-state and datapath selection for the fetch sequence.
    always_comb begin
        state_next   = state_r;
        valid_next   = valid_r;
        addr_next    = addr_r;
        instr_next   = instr_r;
        cnt_next     = cnt_r;
        timeout_next = timeout_r;
        case (state_r)
            FETCHER_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (hit_s) begin
                        state_next = FETCHED;
                        instr_next = hit_data_s;
                    end else begin
                        state_next = FETCHING;
                        valid_next = 1'b1;
                        addr_next  = current_pc;
                        cnt_next   = '0;
                    end
                end else begin
                    state_next = FETCHER_IDLE;
                end
            end
            FETCHING: begin
                if (mem_read_ready) begin
                    state_next = FETCHED;
                    valid_next = 1'b0;
                    instr_next = mem_read_data;
                end else begin
                    // Saturate at the threshold; the timeout flag itself is sticky.
                    if (cnt_r < TIMEOUT_C) begin
                        cnt_next = cnt_r + CNT_BITS'(1);
                    end else begin
                        cnt_next = cnt_r;
                    end
                    if (cnt_next >= TIMEOUT_C) begin
                        timeout_next = 1'b1;
                    end else begin
                        timeout_next = timeout_r;
                    end
                end
            end
            FETCHED: begin
                if (core_state == CORE_DECODE) begin
                    state_next = FETCHER_IDLE;
                end else begin
                    state_next = FETCHED;
                end
            end
            default: begin
                state_next = FETCHER_IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= FETCHER_IDLE;
            valid_r   <= 1'b0;
            addr_r    <= '0;
            instr_r   <= '0;
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next;
            valid_r   <= valid_next;
            addr_r    <= addr_next;
            instr_r   <= instr_next;
            cnt_r     <= cnt_next;
            timeout_r <= timeout_next;
        end
    end

    assign fetcher_state    = state_r;
    assign mem_read_valid   = valid_r;
    assign mem_read_address = addr_r;
    assign instruction      = instr_r;
    assign fetch_timeout    = timeout_r;

endmodule

// File: tb/tb_instr_fetcher.sv
// Self-checking bench for instr_fetcher: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_instr_fetcher;

    localparam int T_OUT   = 4;
    localparam int ENTRIES = 16;
`ifdef FETCH_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [2:0] CS_IDLE   = 3'b000;
    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;
    localparam logic [2:0] CS_EXEC   = 3'b101;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        cache_flush;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_timeout;

    instr_fetcher #(.TIMEOUT_CYCLES(T_OUT), .CACHE_ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .cache_flush      (cache_flush),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .fetch_timeout    (fetch_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Reference model: phase 0 = waiting for FETCH, 1 = request outstanding, 2 = holding word.
    int          m_phase;
    int          m_waits;
    logic [7:0]  m_addr;
    logic [15:0] m_instr;
    bit          m_timeout;
    logic [7:0]  m_line_pc   [int];
    logic [15:0] m_line_data [int];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [2:0] cs, input logic [7:0] pc,
                              input logic rdy, input logic [15:0] d, input logic fl);
        bit fill;
        fill = 1'b0;
        if (r) begin
            m_phase = 0; m_waits = 0; m_addr = 8'h00; m_instr = 16'h0000; m_timeout = 1'b0;
            m_line_pc.delete(); m_line_data.delete();
        end else begin
            if (m_phase == 0) begin
                if (cs == CS_FETCH) begin
                    if (CACHE_EN && m_line_pc.exists(int'(pc) % ENTRIES) &&
                        m_line_pc[int'(pc) % ENTRIES] == pc) begin
                        m_instr = m_line_data[int'(pc) % ENTRIES];
                        m_phase = 2;
                    end else begin
                        m_phase = 1; m_addr = pc; m_waits = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (rdy) begin
                    m_instr = d; m_phase = 2; fill = 1'b1;
                end else begin
                    m_waits++;
                    if (m_waits >= T_OUT) m_timeout = 1'b1;
                end
            end else begin
                if (cs == CS_DECODE) m_phase = 0;
            end
            if (CACHE_EN) begin
                if (fl) begin
                    m_line_pc.delete(); m_line_data.delete();
                end else if (fill) begin
                    m_line_pc[int'(m_addr) % ENTRIES]   = m_addr;
                    m_line_data[int'(m_addr) % ENTRIES] = d;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [2:0] cs, input logic [7:0] pc,
                        input logic rdy, input logic [15:0] d, input logic fl);
        reset = r; core_state = cs; current_pc = pc;
        mem_read_ready = rdy; mem_read_data = d; cache_flush = fl;
        @(posedge clk);
        model_step(r, cs, pc, rdy, d, fl);
        #1;
    endtask

    // Per-cycle comparison of every output against the model, away from the clock edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("state", {29'd0, fetcher_state},
                (m_phase == 0) ? 32'd0 : (m_phase == 1) ? 32'd1 : 32'd2);
            chk("valid", {31'd0, mem_read_valid}, (m_phase == 1) ? 32'd1 : 32'd0);
            chk("address", {24'd0, mem_read_address}, {24'd0, m_addr});
            chk("instruction", {16'd0, instruction}, {16'd0, m_instr});
            chk("timeout", {31'd0, fetch_timeout}, {31'd0, m_timeout});
        end
    end

    initial begin
        int vcount;
        logic [2:0] cs;
        step(1'b1, CS_IDLE, 8'h00, 1'b0, 16'h0000, 1'b0);
        step(1'b1, CS_IDLE, 8'h00, 1'b0, 16'h0000, 1'b0);
        check_en = 1'b1;
        chk("reset_state", {29'd0, fetcher_state}, 32'd0);
        chk("reset_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("reset_instr", {16'd0, instruction}, 32'd0);

        // Fetch 0x05 with three wait cycles, PC changing mid-request.
        vcount = 0;
        step(1'b0, CS_FETCH, 8'h05, 1'b0, 16'hdead, 1'b0);
        if (mem_read_valid) vcount++;
        chk("req_addr", {24'd0, mem_read_address}, 32'h05);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, CS_FETCH, 8'h09, 1'b0, 16'hbeef, 1'b0);
            if (mem_read_valid) vcount++;
        end
        chk("held_addr", {24'd0, mem_read_address}, 32'h05);
        step(1'b0, CS_FETCH, 8'h09, 1'b1, 16'h1234, 1'b0);
        if (mem_read_valid) vcount++;
        chk("valid_cycles", vcount, 32'd4);
        chk("fetched_state", {29'd0, fetcher_state}, 32'd2);
        chk("fetched_instr", {16'd0, instruction}, 32'h1234);

        // FETCHED ignores FETCH until DECODE is seen.
        for (int i = 0; i < 5; i++) step(1'b0, CS_FETCH, 8'h05, 1'b1, 16'h7777, 1'b0);
        chk("no_refetch", {31'd0, mem_read_valid}, 32'd0);
        step(1'b0, CS_DECODE, 8'h05, 1'b0, 16'h0000, 1'b0);
        chk("decode_idle", {29'd0, fetcher_state}, 32'd0);
        chk("decode_instr", {16'd0, instruction}, 32'h1234);

`ifdef FETCH_CACHE_EN
        step(1'b0, CS_FETCH, 8'h05, 1'b0, 16'h0000, 1'b0);
        chk("hit_state", {29'd0, fetcher_state}, 32'd2);
        chk("hit_valid", {31'd0, mem_read_valid}, 32'd0);
        step(1'b0, CS_DECODE, 8'h05, 1'b0, 16'h0000, 1'b1);
        step(1'b0, CS_FETCH, 8'h05, 1'b0, 16'h0000, 1'b0);
        chk("flush_refetch", {31'd0, mem_read_valid}, 32'd1);
        step(1'b0, CS_FETCH, 8'h05, 1'b1, 16'h4321, 1'b0);
        step(1'b0, CS_DECODE, 8'h05, 1'b0, 16'h0000, 1'b0);
`endif

        // Memory never ready: timeout after T_OUT wait cycles, request persists.
        step(1'b0, CS_FETCH, 8'h22, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < T_OUT - 1; i++) step(1'b0, CS_EXEC, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("timeout_not_yet", {31'd0, fetch_timeout}, 32'd0);
        step(1'b0, CS_EXEC, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("timeout_set", {31'd0, fetch_timeout}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, CS_EXEC, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("timeout_sticky", {31'd0, fetch_timeout}, 32'd1);
        chk("valid_after_timeout", {31'd0, mem_read_valid}, 32'd1);

        // Reset mid-request.
        step(1'b1, CS_EXEC, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("rst_state", {29'd0, fetcher_state}, 32'd0);
        chk("rst_valid", {31'd0, mem_read_valid}, 32'd0);
        chk("rst_instr", {16'd0, instruction}, 32'd0);
        chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(9))
                0, 1, 2, 3: cs = CS_FETCH;
                4, 5, 6:    cs = CS_DECODE;
                default:    cs = 3'($urandom_range(7));
            endcase
            step(($urandom_range(99) < 2), cs, 8'($urandom_range(47)),
                 ($urandom_range(99) < 35), 16'($urandom), ($urandom_range(99) < 4));
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
